// File: rtl/pattern_responder.sv
// Pattern store/replay responder for the game controller strobe interface.
// Optional PATTERN_PARITY_EN adds an even-parity bit per entry, checked on replay.
module pattern_responder #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned WIDTH       = 2,
    parameter int unsigned HOLD_CYCLES = 50,
    parameter int unsigned SCORE_W     = 9
) (
    input  logic               clka,
    input  logic               reset,
    input  logic               restart,
    input  logic               load_data,
    input  logic               read_data,
    input  logic               write_out,
    input  logic [WIDTH-1:0]   din,
    output logic [WIDTH-1:0]   dout,
    output logic               lose_sig,
    output logic               timer_done,
    output logic [SCORE_W-1:0] score,
    output logic               proto_err,
    output logic               busy
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
`ifdef PATTERN_PARITY_EN
    localparam int unsigned MW = WIDTH + 1;
`else
    localparam int unsigned MW = WIDTH;
`endif
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_READ,
        S_COMMIT,
        S_HOLD
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [WIDTH-1:0]   din_q, din_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic               lose_q, lose_d;
    logic               timer_q, timer_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic               perr_q, perr_d;
`ifdef PATTERN_PARITY_EN
    logic               par_q, par_d;
`endif

    logic [MW-1:0]      mem_q [DEPTH];
    logic [MW-1:0]      wr_word;
    logic [MW-1:0]      rd_word;
    logic               active;
    logic               do_load;
    logic               do_read;

`ifdef PATTERN_PARITY_EN
    assign wr_word = {^din, din};
`else
    assign wr_word = din;
`endif
    assign rd_word = mem_q[rd_ptr_q];

    // Strobes are acted on in the cycle they are seen, including the cycle
    // that leaves S_IDLE, so no entry is lost on the way into S_LOAD/S_READ.
    assign active  = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_READ);
    assign do_load = active && load_data && !restart;
    assign do_read = active && read_data && !load_data && !restart;

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        hold_d    = hold_q;
        dout_d    = dout_q;
        din_d     = din_q;
        cmp_vld_d = 1'b0;
        lose_d    = lose_q;
        timer_d   = timer_q;
        score_d   = score_q;
        perr_d    = perr_q;
`ifdef PATTERN_PARITY_EN
        par_d     = par_q;
`endif
        if (restart) begin
            state_d  = S_IDLE;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            hold_d   = '0;
            dout_d   = '0;
            lose_d   = 1'b0;
            timer_d  = 1'b0;
            score_d  = '0;
            perr_d   = 1'b0;
        end else begin
            if (cmp_vld_q && (din_q != dout_q)) begin
                lose_d = 1'b1;
            end
`ifdef PATTERN_PARITY_EN
            if (cmp_vld_q && (^{par_q, dout_q})) begin
                perr_d = 1'b1;
            end
`endif
            if (load_data && read_data) begin
                perr_d = 1'b1;
            end
            if (do_load) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (do_read) begin
                dout_d    = rd_word[WIDTH-1:0];
                din_d     = din;
                cmp_vld_d = 1'b1;
                rd_ptr_d  = rd_ptr_q + 1'b1;
`ifdef PATTERN_PARITY_EN
                par_d     = rd_word[WIDTH];
`endif
            end
            if (do_load || do_read) begin
                timer_d = 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (load_data) begin
                        state_d = S_LOAD;
                    end else if (read_data) begin
                        state_d = S_READ;
                    end else if (write_out) begin
                        state_d = S_COMMIT;
                    end
                end
                S_LOAD: begin
                    if (!load_data) begin
                        state_d = write_out ? S_COMMIT : S_IDLE;
                    end
                end
                S_READ: begin
                    if (load_data) begin
                        state_d = S_LOAD;
                    end else if (!read_data) begin
                        state_d = write_out ? S_COMMIT : S_IDLE;
                    end
                end
                S_COMMIT: begin
                    if (!lose_q && (score_q != '1)) begin
                        score_d = score_q + 1'b1;
                    end
                    if (write_out) begin
                        perr_d = 1'b1;
                    end
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    hold_d   = '0;
                    state_d  = S_HOLD;
                end
                S_HOLD: begin
                    if (load_data || read_data || write_out) begin
                        perr_d = 1'b1;
                    end
                    if (hold_q == HOLD_LAST) begin
                        timer_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            hold_q    <= '0;
            dout_q    <= '0;
            din_q     <= '0;
            cmp_vld_q <= 1'b0;
            lose_q    <= 1'b0;
            timer_q   <= 1'b0;
            score_q   <= '0;
            perr_q    <= 1'b0;
`ifdef PATTERN_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            hold_q    <= hold_d;
            dout_q    <= dout_d;
            din_q     <= din_d;
            cmp_vld_q <= cmp_vld_d;
            lose_q    <= lose_d;
            timer_q   <= timer_d;
            score_q   <= score_d;
            perr_q    <= perr_d;
`ifdef PATTERN_PARITY_EN
            par_q     <= par_d;
`endif
        end
    end

    // Pattern memory is intentionally not cleared by reset or restart.
    always_ff @(posedge clka) begin
        if (!reset && do_load) begin
            mem_q[wr_ptr_q] <= wr_word;
        end
    end

    assign dout       = dout_q;
    assign lose_sig   = lose_q;
    assign timer_done = timer_q;
    assign score      = score_q;
    assign proto_err  = perr_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_pattern_responder.sv
// Scoreboard bench for pattern_responder: replay data is predicted from a
// bench-side pattern model and compared as the DUT presents it.
module tb_pattern_responder;

    localparam int DEPTH = 16;
    localparam int WIDTH = 2;
    localparam int HOLD  = 50;
    localparam int SW    = 9;

    logic             clka = 1'b0;
    logic             reset;
    logic             restart;
    logic             load_data;
    logic             read_data;
    logic             write_out;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             lose_sig;
    logic             timer_done;
    logic [SW-1:0]    score;
    logic             proto_err;
    logic             busy;

    int n_cmp = 0;
    int n_bad = 0;
    logic [WIDTH-1:0] model_mem [DEPTH];
    logic [WIDTH-1:0] exp_q [$];
    int wp = 0;
    int rp = 0;

    pattern_responder #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH),
        .HOLD_CYCLES(HOLD),
        .SCORE_W(SW)
    ) dut (
        .clka(clka),
        .reset(reset),
        .restart(restart),
        .load_data(load_data),
        .read_data(read_data),
        .write_out(write_out),
        .din(din),
        .dout(dout),
        .lose_sig(lose_sig),
        .timer_done(timer_done),
        .score(score),
        .proto_err(proto_err),
        .busy(busy)
    );

    always #5 clka = ~clka;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic strobes_off();
        load_data = 1'b0;
        read_data = 1'b0;
        write_out = 1'b0;
        restart   = 1'b0;
    endtask

    task automatic load_one(input logic [WIDTH-1:0] v);
        load_data = 1'b1;
        read_data = 1'b0;
        din = v;
        model_mem[wp] = v;
        wp = (wp + 1) % DEPTH;
        tick();
    endtask

    task automatic read_one(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] e;
        load_data = 1'b0;
        read_data = 1'b1;
        din = v;
        exp_q.push_back(model_mem[rp]);
        rp = (rp + 1) % DEPTH;
        tick();
        e = exp_q.pop_front();
        check_eq("dout", 32'(dout), 32'(e));
    endtask

    task automatic do_restart();
        strobes_off();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        wp = 0;
        rp = 0;
    endtask

    // write_out edge, then the S_COMMIT edge; leaves the DUT at hold count 0
    task automatic commit_round();
        load_data = 1'b0;
        read_data = 1'b0;
        write_out = 1'b1;
        tick();
        write_out = 1'b0;
        tick();
        wp = 0;
        rp = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        din = '0;
        strobes_off();
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        check_eq("rst_dout", 32'(dout), 0);
        check_eq("rst_lose", 32'(lose_sig), 0);
        check_eq("rst_timer", 32'(timer_done), 0);
        check_eq("rst_score", 32'(score), 0);
        check_eq("rst_perr", 32'(proto_err), 0);
        check_eq("rst_busy", 32'(busy), 0);

        // Clean round: load and replay 1,2,3,0
        load_one(2'd1);
        check_eq("busy_load", 32'(busy), 1);
        load_one(2'd2);
        load_one(2'd3);
        load_one(2'd0);
        read_one(2'd1);
        read_one(2'd2);
        read_one(2'd3);
        read_one(2'd0);
        commit_round();
        check_eq("score_1", 32'(score), 1);
        check_eq("lose_clean", 32'(lose_sig), 0);
        repeat (HOLD - 1) tick();
        check_eq("timer_early", 32'(timer_done), 0);
        tick();
        check_eq("timer_on", 32'(timer_done), 1);
        check_eq("busy_idle", 32'(busy), 0);
        check_eq("perr_clean", 32'(proto_err), 0);

        // Mismatch round: replay 1,2,2,0
        load_one(2'd1);
        check_eq("timer_clr", 32'(timer_done), 0);
        load_one(2'd2);
        load_one(2'd3);
        load_one(2'd0);
        read_one(2'd1);
        read_one(2'd2);
        read_one(2'd2);
        check_eq("lose_not_yet", 32'(lose_sig), 0);
        read_one(2'd0);
        read_data = 1'b0;
        write_out = 1'b1;
        tick();
        check_eq("lose_set", 32'(lose_sig), 1);
        write_out = 1'b0;
        tick();
        check_eq("score_held", 32'(score), 1);
        do_restart();
        check_eq("rs_lose", 32'(lose_sig), 0);
        check_eq("rs_score", 32'(score), 0);
        check_eq("rs_busy", 32'(busy), 0);

        // Pointer wrap: 18 loads then one more, replay entries 0..2
        for (int k = 0; k < 18; k++) load_one(2'(k % 4));
        load_one(2'd3);
        read_one(model_mem[0]);
        read_one(model_mem[1]);
        read_one(model_mem[2]);
        read_data = 1'b0;
        tick();
        check_eq("wrap_lose", 32'(lose_sig), 0);
        check_eq("wrap_perr", 32'(proto_err), 0);

        // Simultaneous strobes: load wins, error flagged
        do_restart();
        check_eq("rs_perr", 32'(proto_err), 0);
        load_data = 1'b1;
        read_data = 1'b1;
        din = 2'd2;
        model_mem[wp] = 2'd2;
        wp = (wp + 1) % DEPTH;
        tick();
        check_eq("both_perr", 32'(proto_err), 1);
        read_one(2'd2);
        commit_round();
        read_data = 1'b1;
        din = 2'd1;
        repeat (3) tick();
        read_data = 1'b0;
        check_eq("hold_dout", 32'(dout), 2);
        repeat (HOLD - 4) tick();
        check_eq("hold_timer_early", 32'(timer_done), 0);
        tick();
        check_eq("hold_timer_on", 32'(timer_done), 1);
        check_eq("hold_perr", 32'(proto_err), 1);
        check_eq("hold_lose", 32'(lose_sig), 0);

        // write_out held into S_COMMIT is a protocol error; commit still counts
        do_restart();
        write_out = 1'b1;
        tick();
        tick();
        write_out = 1'b0;
        check_eq("wo_perr", 32'(proto_err), 1);
        check_eq("wo_score", 32'(score), 1);
        repeat (HOLD) tick();
        check_eq("wo_timer", 32'(timer_done), 1);

        // Score saturation
        do_restart();
        for (int i = 0; i < 512; i++) begin
            commit_round();
            repeat (HOLD) tick();
        end
        check_eq("score_sat", 32'(score), 511);

`ifdef PATTERN_PARITY_EN
        do_restart();
        load_one(2'd1);
        load_one(2'd2);
        load_data = 1'b0;
        dut.mem_q[0][WIDTH] = ~dut.mem_q[0][WIDTH];
        read_one(2'd1);
        read_one(2'd2);
        read_data = 1'b0;
        tick();
        check_eq("par_perr", 32'(proto_err), 1);
        check_eq("par_lose", 32'(lose_sig), 0);
`endif

        check_eq("sb_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
